// File: rtl/hazard_control_unit_pkg.sv
// Shared core definitions for the hazard controller slice.
//   REG_ADDR_W   : register-file address width
//   fwd_sel_t    : operand forwarding select (RF / W / M)
//   mem_state_t  : data-memory wait FSM state encoding
package core_pkg;

   localparam int unsigned REG_ADDR_W = 5;

   typedef enum logic [1:0] {
      FWD_RF = 2'b00,
      FWD_W  = 2'b01,
      FWD_M  = 2'b10
   } fwd_sel_t;

   typedef enum logic {
      RUN  = 1'b0,
      WAIT = 1'b1
   } mem_state_t;

endpackage

// File: rtl/hazard_control_unit_if.sv
// Hazard bus between the pipeline datapath and the hazard controller.
//   master : datapath side; drives stage register fields and the dmem handshake,
//            receives forwarding selects, stalls, flushE and memErr
//   slave  : hazard controller side; the mirror image of master
interface hazard_control_unit_if
   import core_pkg::*;
#(
   parameter int unsigned AW = core_pkg::REG_ADDR_W
);
   logic [AW-1:0] rsD, rtD, rsE, rtE, writeRegE, writeRegM, writeRegW;
   logic          branchD, regWriteE, memToRegE, regWriteM, memToRegM, regWriteW;
   logic          dmemReqM, dmemReadyM;
   logic [1:0]    forwardAE, forwardBE;
   logic          forwardAD, forwardBD;
   logic          stallF, stallD, stallE, stallM, flushE, memErr;

   modport master (
      output rsD, rtD, rsE, rtE, writeRegE, writeRegM, writeRegW,
      output branchD, regWriteE, memToRegE, regWriteM, memToRegM, regWriteW,
      output dmemReqM, dmemReadyM,
      input  forwardAE, forwardBE, forwardAD, forwardBD,
      input  stallF, stallD, stallE, stallM, flushE, memErr
   );

   modport slave (
      input  rsD, rtD, rsE, rtE, writeRegE, writeRegM, writeRegW,
      input  branchD, regWriteE, memToRegE, regWriteM, memToRegM, regWriteW,
      input  dmemReqM, dmemReadyM,
      output forwardAE, forwardBE, forwardAD, forwardBD,
      output stallF, stallD, stallE, stallM, flushE, memErr
   );
endinterface

// File: rtl/hazard_control_unit_mem_wait_fsm.sv
// Data-memory wait FSM with timeout counter and sticky error flag.
//   clk, reset (async, active-low)
//   dmemReqM, dmemReadyM : memory-stage request / completion handshake
//   memStall             : freeze the pipe while an access is outstanding
//   memErr               : sticky, set when MEM_TIMEOUT wait cycles pass without ready
module mem_wait_fsm
   import core_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 16
)(
   input  logic clk,
   input  logic reset,
   input  logic dmemReqM,
   input  logic dmemReadyM,
   output logic memStall,
   output logic memErr
);
   localparam int unsigned    CNT_W   = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

   mem_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_d;
   logic             timeout;

   // The counter reaching MEM_TIMEOUT means that many WAIT cycles have passed;
   // that cycle is no longer stalled and the access is abandoned.
   assign timeout = (state_q == WAIT) && (cnt_q == CNT_MAX);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= RUN;
         cnt_q   <= '0;
         memErr  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         memErr  <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = memErr;
      unique case (state_q)
         RUN: begin
            cnt_d = '0;
            if (dmemReqM && !dmemReadyM) begin
               state_d = WAIT;
               cnt_d   = CNT_W'(1);
            end
         end
         WAIT: begin
            if (dmemReadyM) begin
               // ready wins over a simultaneous timeout
               state_d = RUN;
               cnt_d   = '0;
            end else if (timeout) begin
               state_d = RUN;
               cnt_d   = '0;
               err_d   = 1'b1;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = RUN;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      memStall = 1'b0;
      if (state_q == RUN)
         memStall = dmemReqM && !dmemReadyM;
      else
         memStall = !dmemReadyM && !timeout;
   end
endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller for the 5-stage MIPS core.
//   clk, reset (async, active-low)
//   hz (slave)  : stage register fields and dmem handshake in; forwarding selects,
//                 stallF/D/E/M, flushE and memErr out
//   stallCnt, flushCnt : performance counters, present only when
//                        HAZARD_PERF_CNT_EN is defined
module hazard_control_unit
   import core_pkg::*;
#(
   parameter int unsigned REG_ADDR_W  = core_pkg::REG_ADDR_W,
   parameter int unsigned MEM_TIMEOUT = 16
`ifdef HAZARD_PERF_CNT_EN
   ,
   parameter int unsigned PERF_CNT_W  = 32
`endif
)(
   input  logic                  clk,
   input  logic                  reset,
   hazard_control_unit_if.slave  hz
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [PERF_CNT_W-1:0] stallCnt,
   output logic [PERF_CNT_W-1:0] flushCnt
`endif
);
   logic [REG_ADDR_W-1:0] rsD, rtD, rsE, rtE, wrE, wrM, wrW;
   logic                  lwStall, brStall, memStall;
   fwd_sel_t              fwdA, fwdB;

   assign rsD = hz.rsD;
   assign rtD = hz.rtD;
   assign rsE = hz.rsE;
   assign rtE = hz.rtE;
   assign wrE = hz.writeRegE;
   assign wrM = hz.writeRegM;
   assign wrW = hz.writeRegW;

   mem_wait_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_mem_wait (
      .clk        (clk),
      .reset      (reset),
      .dmemReqM   (hz.dmemReqM),
      .dmemReadyM (hz.dmemReadyM),
      .memStall   (memStall),
      .memErr     (hz.memErr)
   );

   assign lwStall = hz.memToRegE && (rtE != '0) && ((rtE == rsD) || (rtE == rtD));
   assign brStall = hz.branchD &&
                    ((hz.regWriteE && (wrE != '0) && ((wrE == rsD) || (wrE == rtD))) ||
                     (hz.memToRegM && (wrM != '0) && ((wrM == rsD) || (wrM == rtD))));

   always_comb begin
      fwdA = FWD_RF;
      fwdB = FWD_RF;
      if (hz.regWriteM && (rsE != '0) && (rsE == wrM))      fwdA = FWD_M;
      else if (hz.regWriteW && (rsE != '0) && (rsE == wrW)) fwdA = FWD_W;
      if (hz.regWriteM && (rtE != '0) && (rtE == wrM))      fwdB = FWD_M;
      else if (hz.regWriteW && (rtE != '0) && (rtE == wrW)) fwdB = FWD_W;
   end

   // Outputs are forced to their reset values combinationally while reset is low.
   always_comb begin
      hz.forwardAE = FWD_RF;
      hz.forwardBE = FWD_RF;
      hz.forwardAD = 1'b0;
      hz.forwardBD = 1'b0;
      hz.stallF    = 1'b0;
      hz.stallD    = 1'b0;
      hz.stallE    = 1'b0;
      hz.stallM    = 1'b0;
      hz.flushE    = 1'b0;
      if (!reset) begin
         hz.flushE = 1'b1;
      end else begin
         hz.forwardAE = fwdA;
         hz.forwardBE = fwdB;
         hz.forwardAD = hz.regWriteM && (rsD != '0) && (rsD == wrM);
         hz.forwardBD = hz.regWriteM && (rtD != '0) && (rtD == wrM);
         if (memStall) begin
            hz.stallF = 1'b1;
            hz.stallD = 1'b1;
            hz.stallE = 1'b1;
            hz.stallM = 1'b1;
         end else if (lwStall || brStall) begin
            hz.stallF = 1'b1;
            hz.stallD = 1'b1;
            hz.flushE = 1'b1;
         end
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stallCnt <= '0;
         flushCnt <= '0;
      end else begin
         if (hz.stallF) stallCnt <= stallCnt + 1'b1;
         if (hz.flushE) flushCnt <= flushCnt + 1'b1;
      end
   end
`endif
endmodule

// File: tb/tb_hazard_control_unit.sv
module tb_hazard_control_unit;
   import core_pkg::*;

   typedef struct {
      string      name;
      logic [11:0] v;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;
   exp_t sbq[$];

   hazard_control_unit_if hz ();

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stallCnt, flushCnt;
   hazard_control_unit #(.MEM_TIMEOUT(4), .PERF_CNT_W(32)) dut (
      .clk(clk), .reset(reset), .hz(hz), .stallCnt(stallCnt), .flushCnt(flushCnt));
`else
   hazard_control_unit #(.MEM_TIMEOUT(4)) dut (
      .clk(clk), .reset(reset), .hz(hz));
`endif

   always #5 clk = ~clk;

   // {forwardAE, forwardBE, forwardAD, forwardBD, stallF, stallD, stallE, stallM, flushE, memErr}
   function automatic logic [11:0] mk(logic [1:0] fae, logic [1:0] fbe, logic fad, logic fbd,
                                      logic sf, logic sd, logic se, logic sm, logic fe, logic err);
      return {fae, fbe, fad, fbd, sf, sd, se, sm, fe, err};
   endfunction

   localparam logic [11:0] NONE = 12'b00_00_0_0_0_0_0_0_0_0;
   localparam logic [11:0] HZ   = 12'b00_00_0_0_1_1_0_0_1_0;
   localparam logic [11:0] MEM  = 12'b00_00_0_0_1_1_1_1_0_0;
   localparam logic [11:0] RST  = 12'b00_00_0_0_0_0_0_0_1_0;
   localparam logic [11:0] ERR  = 12'b00_00_0_0_0_0_0_0_0_1;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      hz.rsD = '0; hz.rtD = '0; hz.rsE = '0; hz.rtE = '0;
      hz.writeRegE = '0; hz.writeRegM = '0; hz.writeRegW = '0;
      hz.branchD = 1'b0; hz.regWriteE = 1'b0; hz.memToRegE = 1'b0;
      hz.regWriteM = 1'b0; hz.memToRegM = 1'b0; hz.regWriteW = 1'b0;
      hz.dmemReqM = 1'b0; hz.dmemReadyM = 1'b0;
   endtask

   task automatic push(input string n, input logic [11:0] e);
      exp_t x;
      x.name = n;
      x.v    = e;
      sbq.push_back(x);
   endtask

   // Monitor: outputs are combinational, sampled mid-cycle on the falling edge.
   always @(negedge clk) begin
      if (sbq.size() > 0) begin
         exp_t x;
         logic [11:0] act;
         x   = sbq.pop_front();
         act = {hz.forwardAE, hz.forwardBE, hz.forwardAD, hz.forwardBD,
                hz.stallF, hz.stallD, hz.stallE, hz.stallM, hz.flushE, hz.memErr};
         total++;
         if (act !== x.v) begin
            bad++;
            $display("FAIL %s: got %b want %b", x.name, act, x.v);
         end
      end
   end

   initial begin
      clr();
      reset = 1'b0;

      // reset state, with forwarding-capable inputs present
      cyc(); hz.regWriteM = 1'b1; hz.writeRegM = 5'd8; hz.rsE = 5'd8; hz.rsD = 5'd8;
      push("reset_hold", RST);
      cyc(); clr(); reset = 1'b1;
      push("after_reset", NONE);

      // forwarding
      cyc(); clr(); hz.regWriteM = 1'b1; hz.writeRegM = 5'd8; hz.regWriteW = 1'b1; hz.writeRegW = 5'd8; hz.rsE = 5'd8;
      push("fwdAE_M_over_W", mk(2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
      cyc(); hz.rsE = 5'd0;
      push("fwdAE_r0", NONE);
      cyc(); clr(); hz.regWriteW = 1'b1; hz.writeRegW = 5'd8; hz.rtE = 5'd8;
      push("fwdBE_W", mk(2'b00, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0));
      cyc(); clr(); hz.regWriteM = 1'b1; hz.writeRegM = 5'd3; hz.regWriteW = 1'b1; hz.writeRegW = 5'd8;
      hz.rsE = 5'd3; hz.rtE = 5'd8; hz.rsD = 5'd3; hz.rtD = 5'd8;
      push("fwd_mixed", mk(2'b10, 2'b01, 1, 0, 0, 0, 0, 0, 0, 0));

      // load-use
      cyc(); clr(); hz.memToRegE = 1'b1; hz.rtE = 5'd9; hz.rsD = 5'd9;
      push("lw_stall", HZ);
      cyc(); hz.memToRegE = 1'b0;
      push("lw_release", NONE);
      cyc(); clr(); hz.memToRegE = 1'b1;
      push("lw_r0", NONE);

      // branch hazards
      cyc(); clr(); hz.branchD = 1'b1; hz.regWriteE = 1'b1; hz.writeRegE = 5'd4; hz.rtD = 5'd4;
      push("br_stall_E", HZ);
      cyc(); clr(); hz.branchD = 1'b1; hz.regWriteM = 1'b1; hz.writeRegM = 5'd4; hz.rtD = 5'd4;
      push("br_fwdBD", mk(2'b00, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0));
      cyc(); clr(); hz.branchD = 1'b1; hz.memToRegM = 1'b1; hz.regWriteM = 1'b1; hz.writeRegM = 5'd4; hz.rsD = 5'd4;
      push("br_stall_M_load", mk(2'b00, 2'b00, 1, 0, 1, 1, 0, 0, 1, 0));
      cyc(); clr(); hz.regWriteE = 1'b1; hz.writeRegE = 5'd4; hz.rtD = 5'd4;
      push("no_branch", NONE);

      // fresh reset so the perf counters start from zero
      cyc(); clr(); reset = 1'b0;
      push("reset2", RST);
      cyc(); reset = 1'b1;
      push("reset2_release", NONE);

      // memory wait: 3 cycles low then ready; first cycle also has a load-use hazard
      cyc(); clr(); hz.dmemReqM = 1'b1; hz.memToRegE = 1'b1; hz.rtE = 5'd9; hz.rsD = 5'd9;
      push("mem_over_lw", MEM);
      cyc(); clr(); hz.dmemReqM = 1'b1;
      push("mem_wait1", MEM);
      cyc();
      push("mem_wait2", MEM);
      cyc(); hz.dmemReadyM = 1'b1;
      push("mem_ready", NONE);
      cyc(); clr();
      push("mem_back_run", NONE);
`ifdef HAZARD_PERF_CNT_EN
      total++;
      if (stallCnt !== 32'd3) begin bad++; $display("FAIL stallCnt: got %0d want 3", stallCnt); end
      total++;
      if (flushCnt !== 32'd0) begin bad++; $display("FAIL flushCnt: got %0d want 0", flushCnt); end
`endif

      // ready in the 4th wait cycle
      cyc(); clr(); hz.dmemReqM = 1'b1;
      push("rdy4_c0", MEM);
      cyc(); push("rdy4_c1", MEM);
      cyc(); push("rdy4_c2", MEM);
      cyc(); hz.dmemReadyM = 1'b1;
      push("rdy4_c3", NONE);
      cyc(); clr();
      push("rdy4_noerr", NONE);

      // ready in the same cycle as the timeout
      cyc(); hz.dmemReqM = 1'b1;
      push("rdyto_c0", MEM);
      cyc(); push("rdyto_c1", MEM);
      cyc(); push("rdyto_c2", MEM);
      cyc(); push("rdyto_c3", MEM);
      cyc(); clr(); hz.dmemReadyM = 1'b1;
      push("rdyto_c4", NONE);
      cyc(); clr();
      push("rdyto_noerr", NONE);

      // timeout: ready never comes
      cyc(); hz.dmemReqM = 1'b1;
      push("to_c0", MEM);
      cyc(); push("to_c1", MEM);
      cyc(); push("to_c2", MEM);
      cyc(); push("to_c3", MEM);
      cyc(); clr();
      push("to_release", NONE);
      cyc(); push("to_err_set", ERR);
      cyc(); push("to_err_sticky", ERR);

      // asynchronous reset in the middle of WAIT
      cyc(); hz.dmemReqM = 1'b1;
      push("rstw_c0", mk(2'b00, 2'b00, 0, 0, 1, 1, 1, 1, 0, 1));
      cyc(); clr();
      push("rstw_c1", mk(2'b00, 2'b00, 0, 0, 1, 1, 1, 1, 0, 1));
      cyc(); reset = 1'b0;
      push("rstw_async", RST);
      cyc(); reset = 1'b1;
      push("rstw_run", NONE);

      for (int i = 0; i < 20 && sbq.size() != 0; i++) @(posedge clk);
      total++;
      if (sbq.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending want 0", sbq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
